// File: rtl/shared_res_arbiter_if.sv
// Request/grant bundle between NUM_REQ requesters and the shared-resource arbiter.
// Requesters drive req/done; the arbiter drives the grant side.
interface shared_res_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  // Handshake: a requester raises req[i] and holds it until its ownership ends.
  // Ownership begins on the cycle gnt[i] goes high. It ends when done[i] pulses,
  // when req[i] drops, or when the hold limit expires. gnt then drops for at least one cycle.
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout
  );
endinterface

// File: rtl/shared_res_arbiter.sv
// Round-robin arbiter time-sharing one resource among NUM_REQ requesters, with
// bounded ownership (MAX_HOLD cycles) and a one-cycle dead gap between owners.
module shared_res_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 10,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  shared_res_arbiter_if.slave        bus,
  output logic [1:0]                 dbg_state
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    scan_idx;
  logic               own_done;
  logic               own_req;
  logic               expired;

  // First requester at or above ptr, wrapping from NUM_REQ-1 back to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // gnt_id_q holds the owner index for the whole time the FSM sits in GRANT.
  assign own_done = bus.done[gnt_id_q];
  assign own_req  = bus.req[gnt_id_q];
  assign expired  = (hold_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;
    case (state_q)
      S_GRANT: begin
        if (own_done || !own_req || expired) begin
          state_d     = S_GAP;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          ptr_d       = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
          // Expiry only reports when nothing else ended the ownership.
          timeout_d   = expired && own_req && !own_done;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        // IDLE and GAP both arbitrate, so a handover costs exactly one empty cycle.
        if (win_found) begin
          state_d     = S_GRANT;
          gnt_d       = NUM_REQ'(1) << win_idx;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_idx;
          hold_d      = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;
  assign dbg_state     = state_q;

endmodule
